// File: rtl/sram_banked_pkg.sv
// rtl/sram_banked_pkg.sv - shared types and address helpers for the banked SRAM
package sram_banked_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } init_state_e;

    function automatic int unsigned bank_of(input int unsigned addr,
                                            input int unsigned bank_addr_width,
                                            input int unsigned num_banks);
        return (addr >> bank_addr_width) & (num_banks - 1);
    endfunction

    function automatic int unsigned index_of(input int unsigned addr,
                                             input int unsigned bank_addr_width);
        return addr & ((32'd1 << bank_addr_width) - 32'd1);
    endfunction

endpackage

// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - one 1RW1R bank with byte-masked write and registered reads
module sram_bank #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned NUM_WMASKS = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [NUM_WMASKS-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_en,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] merged;

    // New word for a port A write: enabled bytes replaced, others kept
    always_comb begin
        merged = mem[a_addr];
        for (int i = 0; i < int'(NUM_WMASKS); i++) begin
            if (a_be[i]) begin
                merged[i*8 +: 8] = a_wdata[i*8 +: 8];
            end
        end
    end

    // Storage update; contents are not reset
    always_ff @(posedge clk) begin
        if (a_en && a_we) begin
            mem[a_addr] <= merged;
        end
    end

    // Registered reads; port B sees a same-cycle port A write (write-first)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_en && !a_we) begin
                a_rdata <= mem[a_addr];
            end
            if (b_en) begin
                b_rdata <= (a_en && a_we && (a_addr == b_addr)) ? merged : mem[b_addr];
            end
        end
    end

endmodule

// File: rtl/sram_banked.sv
// rtl/sram_banked.sv - banked 1RW1R SRAM with zero-fill init sequencer
module sram_banked
    import sram_banked_pkg::*;
#(
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned BANK_ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter bit          CLEAR_ON_RESET  = 1'b1,
    localparam int unsigned ADDR_WIDTH = BANK_ADDR_WIDTH + $clog2(NUM_BANKS),
    localparam int unsigned NUM_WMASKS = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  init_done_o,
    input  logic                  p0_req_i,
    output logic                  p0_gnt_o,
    input  logic                  p0_we_i,
    input  logic [NUM_WMASKS-1:0] p0_be_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic [DATA_WIDTH-1:0] p0_wdata_i,
    output logic                  p0_rvalid_o,
    output logic [DATA_WIDTH-1:0] p0_rdata_o,
    input  logic                  p1_req_i,
    output logic                  p1_gnt_o,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    output logic                  p1_rvalid_o,
    output logic [DATA_WIDTH-1:0] p1_rdata_o
);

    localparam int unsigned SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    init_state_e                state;
    logic [BANK_ADDR_WIDTH-1:0] clr_cnt;
    logic                       clearing;
    logic                       p0_acc, p1_acc, p0_rd;
    logic [SEL_W-1:0]           p0_bank, p1_bank, p0_sel_q, p1_sel_q;
    logic [BANK_ADDR_WIDTH-1:0] p0_index, p1_index;
    logic [DATA_WIDTH-1:0]      rd_a [NUM_BANKS];
    logic [DATA_WIDTH-1:0]      rd_b [NUM_BANKS];

    assign p0_gnt_o = init_done_o;
    assign p1_gnt_o = init_done_o;
    assign p0_acc   = p0_req_i && init_done_o;
    assign p1_acc   = p1_req_i && init_done_o;
    assign p0_rd    = p0_acc && !p0_we_i;
    assign clearing = (state == CLEAR);

    assign p0_bank  = SEL_W'(bank_of(32'(p0_addr_i), BANK_ADDR_WIDTH, NUM_BANKS));
    assign p1_bank  = SEL_W'(bank_of(32'(p1_addr_i), BANK_ADDR_WIDTH, NUM_BANKS));
    assign p0_index = BANK_ADDR_WIDTH'(index_of(32'(p0_addr_i), BANK_ADDR_WIDTH));
    assign p1_index = BANK_ADDR_WIDTH'(index_of(32'(p1_addr_i), BANK_ADDR_WIDTH));

    // Init sequencer: zero one index of every bank per cycle, then serve requests
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= CLEAR_ON_RESET ? CLEAR : READY;
            clr_cnt     <= '0;
            init_done_o <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + BANK_ADDR_WIDTH'(1);
                    if (clr_cnt == '1) begin
                        state       <= READY;
                        init_done_o <= 1'b1;
                    end
                end
                READY:   init_done_o <= 1'b1;
                default: state <= READY;
            endcase
        end
    end

    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
        logic                       a_en, a_we, b_en;
        logic [NUM_WMASKS-1:0]      a_be;
        logic [BANK_ADDR_WIDTH-1:0] a_addr;
        logic [DATA_WIDTH-1:0]      a_wdata;

        // Port A is owned by the clear sequencer until the memory is ready
        always_comb begin
            if (clearing) begin
                a_en    = 1'b1;
                a_we    = 1'b1;
                a_be    = '1;
                a_addr  = clr_cnt;
                a_wdata = '0;
            end else begin
                a_en    = p0_acc && (p0_bank == SEL_W'(b));
                a_we    = p0_we_i;
                a_be    = p0_be_i;
                a_addr  = p0_index;
                a_wdata = p0_wdata_i;
            end
            b_en = p1_acc && (p1_bank == SEL_W'(b));
        end

        sram_bank #(
            .ADDR_WIDTH (BANK_ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk     (clk_i),
            .rst_n   (rst_ni),
            .a_en    (a_en),
            .a_we    (a_we),
            .a_be    (a_be),
            .a_addr  (a_addr),
            .a_wdata (a_wdata),
            .a_rdata (rd_a[b]),
            .b_en    (b_en),
            .b_addr  (p1_index),
            .b_rdata (rd_b[b])
        );
    end

    // Read response tracking: rvalid pulse and the bank that owns the data
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            p0_rvalid_o <= 1'b0;
            p1_rvalid_o <= 1'b0;
            p0_sel_q    <= '0;
            p1_sel_q    <= '0;
        end else begin
            p0_rvalid_o <= p0_rd;
            p1_rvalid_o <= p1_acc;
            if (p0_rd) begin
                p0_sel_q <= p0_bank;
            end
            if (p1_acc) begin
                p1_sel_q <= p1_bank;
            end
        end
    end

    assign p0_rdata_o = rd_a[p0_sel_q];
    assign p1_rdata_o = rd_b[p1_sel_q];

endmodule

// File: tb/tb_sram_banked.sv
// tb/tb_sram_banked.sv - self-checking bench for sram_banked
module tb_sram_banked;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, init_done;
    logic        p0_req, p0_gnt, p0_we, p0_rvalid;
    logic [3:0]  p0_be;
    logic [10:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p0_rdata, p1_rdata;
    logic        p1_req, p1_gnt, p1_rvalid;

    logic        q_rst_n, q_init_done;
    logic        q_p0_req, q_p0_gnt, q_p0_we, q_p0_rvalid;
    logic [3:0]  q_p0_be;
    logic [8:0]  q_p0_addr, q_p1_addr;
    logic [31:0] q_p0_wdata, q_p0_rdata, q_p1_rdata;
    logic        q_p1_req, q_p1_gnt, q_p1_rvalid;

    sram_banked dut (
        .clk_i(clk), .rst_ni(rst_n), .init_done_o(init_done),
        .p0_req_i(p0_req), .p0_gnt_o(p0_gnt), .p0_we_i(p0_we), .p0_be_i(p0_be),
        .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
        .p1_req_i(p1_req), .p1_gnt_o(p1_gnt), .p1_addr_i(p1_addr),
        .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata)
    );

    sram_banked #(.NUM_BANKS(1), .CLEAR_ON_RESET(1'b0)) dut1 (
        .clk_i(clk), .rst_ni(q_rst_n), .init_done_o(q_init_done),
        .p0_req_i(q_p0_req), .p0_gnt_o(q_p0_gnt), .p0_we_i(q_p0_we), .p0_be_i(q_p0_be),
        .p0_addr_i(q_p0_addr), .p0_wdata_i(q_p0_wdata), .p0_rvalid_o(q_p0_rvalid), .p0_rdata_o(q_p0_rdata),
        .p1_req_i(q_p1_req), .p1_gnt_o(q_p1_gnt), .p1_addr_i(q_p1_addr),
        .p1_rvalid_o(q_p1_rvalid), .p1_rdata_o(q_p1_rdata)
    );

    typedef struct {
        logic        req0, we0;
        logic [3:0]  be;
        logic [10:0] a0;
        logic [31:0] wd;
        logic        req1;
        logic [10:0] a1;
        logic        ev0;
        logic [31:0] ed0;
        logic        ev1;
        logic [31:0] ed1;
    } row_t;

    row_t        tbl[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] mem_m [2048];
    logic        exp_v0, exp_v1;
    logic [31:0] exp_d0, exp_d1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic row_t mk(input logic req0, input logic we0, input logic [3:0] be,
                                input logic [10:0] a0, input logic [31:0] wd,
                                input logic req1, input logic [10:0] a1,
                                input logic ev0, input logic [31:0] ed0,
                                input logic ev1, input logic [31:0] ed1);
        row_t r;
        r.req0 = req0; r.we0 = we0; r.be = be; r.a0 = a0; r.wd = wd;
        r.req1 = req1; r.a1 = a1; r.ev0 = ev0; r.ed0 = ed0; r.ev1 = ev1; r.ed1 = ed1;
        return r;
    endfunction

    // Drive one request cycle and advance the reference model (write lands before the port 1 read)
    task automatic drive(input logic req0, input logic we0, input logic [3:0] be,
                         input logic [10:0] a0, input logic [31:0] wd,
                         input logic req1, input logic [10:0] a1);
        p0_req = req0; p0_we = we0; p0_be = be; p0_addr = a0; p0_wdata = wd;
        p1_req = req1; p1_addr = a1;
        exp_v0 = req0 && !we0;
        if (exp_v0) exp_d0 = mem_m[a0];
        if (req0 && we0) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_m[a0][i*8 +: 8] = wd[i*8 +: 8];
            end
        end
        exp_v1 = req1;
        if (req1) exp_d1 = mem_m[a1];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string name);
        int cycles = 0;
        int early = 0;
        while (!init_done && cycles < 2000) begin
            step();
            cycles++;
            if (p0_rvalid || p1_rvalid || (p0_gnt && !init_done)) early++;
        end
        check({name, "_cycles"}, 32'(cycles), 32'd512);
        check({name, "_no_resp"}, 32'(early), 32'd0);
    endtask

    initial begin
        logic [10:0] hot [8];
        hot[0] = 11'h000; hot[1] = 11'h205; hot[2] = 11'h010; hot[3] = 11'h600;
        hot[4] = 11'h7FF; hot[5] = 11'h3FF; hot[6] = 11'h401; hot[7] = 11'h200;

        rst_n = 1'b0; p0_req = 0; p0_we = 0; p0_be = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_addr = 0;
        q_rst_n = 1'b0; q_p0_req = 0; q_p0_we = 0; q_p0_be = 0; q_p0_addr = 0;
        q_p0_wdata = 0; q_p1_req = 0; q_p1_addr = 0;
        for (int i = 0; i < 2048; i++) mem_m[i] = '0;
        exp_d0 = '0; exp_d1 = '0;

        repeat (3) step();
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd0);
        check("rst_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
        check("rst_rdata0", p0_rdata, 32'd0);
        check("rst_rdata1", p1_rdata, 32'd0);

        // single-bank, no-clear instance while the main one stays in reset
        q_rst_n = 1'b1;
        check("q_done_at_release", {31'd0, q_init_done}, 32'd0);
        step();
        check("q_done_one_cycle", {31'd0, q_init_done}, 32'd1);
        check("q_gnt", {30'd0, q_p0_gnt, q_p1_gnt}, 32'd3);
        q_p0_req = 1; q_p0_we = 1; q_p0_be = 4'hF; q_p0_addr = 9'h1FF; q_p0_wdata = 32'hCAFEF00D;
        step();
        check("q_write_no_rvalid", {31'd0, q_p0_rvalid}, 32'd0);
        q_p0_be = 4'b1000; q_p0_wdata = 32'h55000000;
        step();
        q_p0_we = 0; q_p1_req = 1; q_p1_addr = 9'h1FF;
        step();
        q_p0_req = 0; q_p1_req = 0;
        check("q_rvalid", {30'd0, q_p0_rvalid, q_p1_rvalid}, 32'd3);
        check("q_rdata0", q_p0_rdata, 32'h55FEF00D);
        check("q_rdata1", q_p1_rdata, 32'h55FEF00D);

        // main instance: clear sequence with requests that must be ignored
        rst_n = 1'b1;
        p0_req = 1; p0_we = 1; p0_be = 4'hF; p0_addr = 11'h005; p0_wdata = 32'hFFFFFFFF;
        p1_req = 1; p1_addr = 11'h005;
        wait_init("init");
        p0_req = 0; p1_req = 0; p0_we = 0;
        check("ready_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd3);

        tbl.push_back(mk(1,1,4'hF,11'h205,32'hDEADBEEF, 0,11'h000, 0,32'h0,        0,32'h0));
        tbl.push_back(mk(1,1,4'h5,11'h205,32'h11223344, 0,11'h000, 0,32'h0,        0,32'h0));
        tbl.push_back(mk(0,0,4'h0,11'h000,32'h0,        1,11'h205, 0,32'h0,        1,32'hDE22BE44));
        tbl.push_back(mk(1,1,4'hF,11'h010,32'h12345678, 0,11'h000, 0,32'h0,        0,32'hDE22BE44));
        tbl.push_back(mk(1,1,4'h3,11'h010,32'hAABBCCDD, 1,11'h010, 0,32'h0,        1,32'h1234CCDD));
        tbl.push_back(mk(1,0,4'h0,11'h010,32'h0,        0,11'h000, 1,32'h1234CCDD, 0,32'h1234CCDD));
        tbl.push_back(mk(1,1,4'hF,11'h000,32'hA0000000, 0,11'h000, 0,32'h1234CCDD, 0,32'h1234CCDD));
        tbl.push_back(mk(1,1,4'hF,11'h200,32'hB1111111, 0,11'h000, 0,32'h1234CCDD, 0,32'h1234CCDD));
        tbl.push_back(mk(1,1,4'hF,11'h400,32'hC2222222, 0,11'h000, 0,32'h1234CCDD, 0,32'h1234CCDD));
        tbl.push_back(mk(1,1,4'hF,11'h600,32'hD3333333, 0,11'h000, 0,32'h1234CCDD, 0,32'h1234CCDD));
        tbl.push_back(mk(1,0,4'h0,11'h600,32'h0,        1,11'h000, 1,32'hD3333333, 1,32'hA0000000));
        tbl.push_back(mk(1,0,4'h0,11'h400,32'h0,        1,11'h200, 1,32'hC2222222, 1,32'hB1111111));
        tbl.push_back(mk(1,0,4'h0,11'h200,32'h0,        1,11'h400, 1,32'hB1111111, 1,32'hC2222222));
        tbl.push_back(mk(1,0,4'h0,11'h000,32'h0,        1,11'h600, 1,32'hA0000000, 1,32'hD3333333));
        tbl.push_back(mk(1,1,4'h0,11'h600,32'hFFFFFFFF, 1,11'h600, 0,32'hA0000000, 1,32'hD3333333));
        tbl.push_back(mk(1,0,4'h0,11'h7FF,32'h0,        1,11'h005, 1,32'h0,        1,32'h0));
        tbl.push_back(mk(1,0,4'h0,11'h005,32'h0,        1,11'h600, 1,32'h0,        1,32'hD3333333));
        tbl.push_back(mk(0,0,4'h0,11'h000,32'h0,        0,11'h000, 0,32'h0,        0,32'hD3333333));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].req0, tbl[i].we0, tbl[i].be, tbl[i].a0, tbl[i].wd, tbl[i].req1, tbl[i].a1);
            step();
            check($sformatf("tbl%0d_v0", i), {31'd0, p0_rvalid}, {31'd0, tbl[i].ev0});
            check($sformatf("tbl%0d_d0", i), p0_rdata, tbl[i].ed0);
            check($sformatf("tbl%0d_v1", i), {31'd0, p1_rvalid}, {31'd0, tbl[i].ev1});
            check($sformatf("tbl%0d_d1", i), p1_rdata, tbl[i].ed1);
        end

        // randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [10:0] ra0, ra1;
            ra0 = ($urandom_range(1) == 1) ? hot[$urandom_range(7)] : 11'($urandom);
            ra1 = ($urandom_range(1) == 1) ? hot[$urandom_range(7)] : 11'($urandom);
            if ($urandom_range(3) == 0) ra1 = ra0;
            drive($urandom_range(3) != 0, 1'($urandom), 4'($urandom), ra0, $urandom,
                  $urandom_range(3) != 0, ra1);
            step();
            check($sformatf("rnd%0d_v0", n), {31'd0, p0_rvalid}, {31'd0, exp_v0});
            check($sformatf("rnd%0d_d0", n), p0_rdata, exp_d0);
            check($sformatf("rnd%0d_v1", n), {31'd0, p1_rvalid}, {31'd0, exp_v1});
            check($sformatf("rnd%0d_d1", n), p1_rdata, exp_d1);
        end

        // reset in the cycle right after a read was accepted
        drive(1, 0, 4'h0, 11'h205, 32'h0, 1, 11'h010);
        step();
        rst_n = 1'b0; p0_req = 0; p1_req = 0;
        step();
        check("abort_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
        check("abort_rdata0", p0_rdata, 32'd0);
        check("abort_rdata1", p1_rdata, 32'd0);
        check("abort_init_done", {31'd0, init_done}, 32'd0);
        rst_n = 1'b1;
        wait_init("reinit");
        for (int i = 0; i < 2048; i++) mem_m[i] = '0;
        drive(1, 0, 4'h0, 11'h010, 32'h0, 1, 11'h205);
        step();
        p0_req = 0; p1_req = 0;
        check("reinit_rdata0", p0_rdata, 32'd0);
        check("reinit_rdata1", p1_rdata, 32'd0);
        check("reinit_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
